// File: rtl/vld_pulse_gen.sv
// Valid-pulse generator: accepts a pulse count, emits that many one-cycle
// dout_vld strobes spaced by GAP idle cycles, then a one-cycle done strobe.
module vld_pulse_gen #(
  parameter int DW  = 12,
  parameter int GAP = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          din_rdy,
  input  logic          clr,
  output logic          dout_vld,
  output logic [DW-1:0] pulse_cnt,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, DONE} state_t;

  state_t        state;
  logic [DW-1:0] target;
  logic [7:0]    gap_cnt;
  logic [DW-1:0] cnt_nxt;

  assign cnt_nxt = pulse_cnt + DW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target    <= '0;
      gap_cnt   <= '0;
      pulse_cnt <= '0;
    end else if (clr) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      pulse_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (din_vld) begin
          target    <= din;
          pulse_cnt <= '0;
          state     <= (din == '0) ? DONE : PULSE;
        end
        PULSE: begin
          // target never exceeds 2^DW-1, so cnt_nxt cannot wrap here
          pulse_cnt <= cnt_nxt;
          if (cnt_nxt == target)
            state <= DONE;
          else if (GAP == 0)
            state <= PULSE;
          else begin
            state   <= WAIT;
            gap_cnt <= 8'(GAP - 1);
          end
        end
        WAIT: begin
          if (gap_cnt == '0) state <= PULSE;
          else               gap_cnt <= gap_cnt - 8'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state only: no path from din_vld.
  assign din_rdy  = (state == IDLE);
  assign dout_vld = (state == PULSE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_vld_pulse_gen.sv
// Scoreboard bench for vld_pulse_gen: two instances (GAP=3 and GAP=0); the
// expected pulse/done events with their cycle numbers are queued at accept time.
module tb_vld_pulse_gen;
  localparam int DW = 12;

  typedef struct {
    int id;
    bit is_done;
    int cyc;
    int cnt;
  } ev_t;

  logic          clk, rst_n;
  logic [DW-1:0] din_a  [2];
  logic          din_vld_a [2];
  logic          din_rdy_a [2];
  logic          clr_a  [2];
  logic          vld_a  [2];
  logic [DW-1:0] pcnt_a [2];
  logic          done_a [2];

  ev_t exp_q[$];
  int  cyc, n_cmp, n_err;
  int  tot [2];

  vld_pulse_gen #(.DW(DW), .GAP(3)) u_g3 (
    .clk(clk), .rst_n(rst_n), .din(din_a[0]), .din_vld(din_vld_a[0]),
    .din_rdy(din_rdy_a[0]), .clr(clr_a[0]), .dout_vld(vld_a[0]),
    .pulse_cnt(pcnt_a[0]), .done(done_a[0]));

  vld_pulse_gen #(.DW(DW), .GAP(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .din(din_a[1]), .din_vld(din_vld_a[1]),
    .din_rdy(din_rdy_a[1]), .clr(clr_a[1]), .dout_vld(vld_a[1]),
    .pulse_cnt(pcnt_a[1]), .done(done_a[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic ev(input int d, input bit is_done);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk(is_done ? "unexp_done" : "unexp_pulse", d, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_id", d, e.id);
    chk("ev_kind", int'(is_done), int'(e.is_done));
    chk("ev_cyc", cyc, e.cyc);
    if (is_done) chk("done_cnt", int'(pcnt_a[d]), e.cnt);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (vld_a[d] === 1'b1) begin
        ev(d, 1'b0);
        tot[d]++;
      end
      if (done_a[d] === 1'b1) ev(d, 1'b1);
    end
  end

  // Drive a request, push the events it should produce (npush pulses, and
  // the done strobe if with_done), and return the accept cycle.
  task automatic req(input int d, input int n, input int npush, input bit with_done,
                     input bit keep, output int a);
    int k, g;
    ev_t e;
    g = (d == 0) ? 3 : 0;
    @(negedge clk);
    din_a[d]     = DW'(n);
    din_vld_a[d] = 1'b1;
    k = 0;
    while (din_rdy_a[d] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    a = cyc;
    if (k >= 200) begin
      chk("rdy_timeout", 0, 1);
      din_vld_a[d] = 1'b0;
      return;
    end
    for (int i = 0; i < npush; i++) begin
      e.id = d; e.is_done = 1'b0; e.cyc = a + 1 + i * (g + 1); e.cnt = 0;
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.id = d; e.is_done = 1'b1; e.cnt = n;
      e.cyc = (n == 0) ? a + 1 : a + 1 + (n - 1) * (g + 1) + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep) din_vld_a[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, output int c);
    int k;
    k = 0;
    @(negedge clk);
    while (din_rdy_a[d] !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) chk("idle_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic chk_rst(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_rdy"}, int'(din_rdy_a[d]), 1);
      chk({tag, "_vld"}, int'(vld_a[d]), 0);
      chk({tag, "_cnt"}, int'(pcnt_a[d]), 0);
      chk({tag, "_done"}, int'(done_a[d]), 0);
    end
  endtask

  initial begin
    int a, c, n, sum;
    cyc = 0; n_cmp = 0; n_err = 0; tot[0] = 0; tot[1] = 0;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      din_a[d] = '0; din_vld_a[d] = 1'b0; clr_a[d] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 chk_rst("rst_async");
    repeat (3) @(negedge clk);
    chk_rst("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_rst("rst_after");

    // GAP=3, five pulses
    req(0, 5, 5, 1'b1, 1'b0, a);
    wait_idle(0, c);
    chk("g3_rdy_cyc", c, a + 19);
    chk("g3_cnt", int'(pcnt_a[0]), 5);

    // GAP=0, four back-to-back pulses
    req(1, 4, 4, 1'b1, 1'b0, a);
    wait_idle(1, c);
    chk("g0_rdy_cyc", c, a + 6);
    chk("g0_cnt", int'(pcnt_a[1]), 4);

    // zero-length request
    req(0, 0, 0, 1'b1, 1'b0, a);
    wait_idle(0, c);
    chk("zero_rdy_cyc", c, a + 2);
    chk("zero_cnt", int'(pcnt_a[0]), 0);

    // request while busy is ignored
    req(0, 3, 3, 1'b1, 1'b0, a);
    @(negedge clk);
    din_a[0] = DW'(7);
    din_vld_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    din_vld_a[0] = 1'b0;
    wait_idle(0, c);
    chk("busy_cnt", int'(pcnt_a[0]), 3);
    repeat (10) @(negedge clk);

    // clr on the second pulse
    req(0, 6, 2, 1'b0, 1'b0, a);
    while (cyc < a + 5) @(negedge clk);
    clr_a[0] = 1'b1;
    @(negedge clk);
    clr_a[0] = 1'b0;
    chk("clr_rdy", int'(din_rdy_a[0]), 1);
    chk("clr_cnt", int'(pcnt_a[0]), 0);
    chk("clr_vld", int'(vld_a[0]), 0);
    repeat (30) @(negedge clk);

    // asynchronous reset mid-burst
    req(0, 6, 2, 1'b0, 1'b0, a);
    while (cyc < a + 6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_rst("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk_rst("rst_mid_after");

    // back-to-back random stream feeding the counter model
    tot[0] = 0;
    sum = 0;
    for (int i = 0; i < 50; i++) begin
      n = $urandom_range(0, 5);
      req(0, n, n, 1'b1, 1'b1, a);
      sum += n;
    end
    din_vld_a[0] = 1'b0;
    wait_idle(0, c);
    repeat (5) @(negedge clk);
    chk("stream_total", tot[0], sum);
    chk("q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
